// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller for the openMIPS 5-stage core: merges ID/EX stall requests,
// sequences multi-cycle EX ops and issues redirect flushes. Define STALL_CNT_EN to add stall_cycles.
module pipe_ctrl #(
  parameter int MC_CNT_W = 6
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic                stallreq_id,
  input  logic                stallreq_ex,
  input  logic                mc_start,
  input  logic [MC_CNT_W-1:0] mc_len,
  input  logic                flush_req,
  input  logic [31:0]         flush_pc,
  output logic [5:0]          stall,
  output logic                flush,
  output logic [31:0]         new_pc,
  output logic                mc_busy,
  output logic                mc_done
`ifdef STALL_CNT_EN
  ,
  output logic [31:0]         stall_cycles
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    MC_RUN  = 2'b01,
    MC_DONE = 2'b10
  } state_t;

  localparam logic [MC_CNT_W-1:0] CNT_ZERO = MC_CNT_W'(0);
  localparam logic [MC_CNT_W-1:0] CNT_ONE  = MC_CNT_W'(1);
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;

  state_t              state_r, state_next_s;
  logic [MC_CNT_W-1:0] cnt_r, cnt_next_s;
  logic [MC_CNT_W-1:0] eff_len_s;
  logic                mc_stall_s;
  logic                flush_r;
  logic [31:0]         new_pc_r;
  logic                mc_busy_r, mc_done_r;

  // Zero-length requests still occupy EX for one cycle.
  always_comb begin
    if (mc_len == CNT_ZERO) begin
      eff_len_s = CNT_ONE;
    end else begin
      eff_len_s = mc_len;
    end
  end

  // Next-state logic; a flush request aborts any op and discards a same-cycle start.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    mc_stall_s   = 1'b0;
    case (state_r)
      IDLE, MC_DONE: begin
        if (mc_start && !flush_req) begin
          mc_stall_s = 1'b1;
          if (eff_len_s == CNT_ONE) begin
            state_next_s = MC_DONE;
            cnt_next_s   = CNT_ZERO;
          end else begin
            state_next_s = MC_RUN;
            cnt_next_s   = eff_len_s - CNT_ONE;
          end
        end else begin
          state_next_s = IDLE;
          cnt_next_s   = CNT_ZERO;
        end
      end
      MC_RUN: begin
        mc_stall_s = 1'b1;
        if (cnt_r <= CNT_ONE) begin
          state_next_s = MC_DONE;
          cnt_next_s   = CNT_ZERO;
        end else begin
          state_next_s = MC_RUN;
          cnt_next_s   = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = CNT_ZERO;
      end
    endcase
    if (flush_req) begin
      state_next_s = IDLE;
      cnt_next_s   = CNT_ZERO;
    end else begin
      state_next_s = state_next_s;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst_) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      flush_r   <= 1'b0;
      new_pc_r  <= 32'h0000_0000;
      mc_busy_r <= 1'b0;
      mc_done_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      cnt_r     <= cnt_next_s;
      flush_r   <= flush_req;
      mc_busy_r <= (state_next_s == MC_RUN);
      mc_done_r <= (state_next_s == MC_DONE);
      if (flush_req) begin
        new_pc_r <= flush_pc;
      end else begin
        new_pc_r <= new_pc_r;
      end
    end
  end

  // Zero-latency stall vector; a flush pulse clears the pipe so nothing may hold.
  always_comb begin
    stall = STALL_NONE;
    if (rst_) begin
      stall = STALL_NONE;
    end else if (flush_r) begin
      stall = STALL_NONE;
    end else if (stallreq_ex || mc_stall_s) begin
      stall = STALL_EX;
    end else if (stallreq_id) begin
      stall = STALL_ID;
    end else begin
      stall = STALL_NONE;
    end
  end

  assign flush   = flush_r;
  assign new_pc  = new_pc_r;
  assign mc_busy = mc_busy_r;
  assign mc_done = mc_done_r;

`ifdef STALL_CNT_EN
  logic [31:0] stall_cycles_r;

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk) begin
    if (rst_) begin
      stall_cycles_r <= 32'h0000_0000;
    end else if (stall[0] && (stall_cycles_r != 32'hFFFF_FFFF)) begin
      stall_cycles_r <= stall_cycles_r + 32'h0000_0001;
    end else begin
      stall_cycles_r <= stall_cycles_r;
    end
  end

  assign stall_cycles = stall_cycles_r;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vector table, hand-written corner sequences and a randomized
// run compared against a cycle-count reference model.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_ = 1'b1;
  logic        stallreq_id = 1'b0, stallreq_ex = 1'b0, mc_start = 1'b0, flush_req = 1'b0;
  logic [5:0]  mc_len = 6'd0;
  logic [31:0] flush_pc = 32'h0;
  logic [5:0]  stall;
  logic        flush, mc_busy, mc_done;
  logic [31:0] new_pc;
`ifdef STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int n_pass = 0;
  int n_total = 0;

  pipe_ctrl #(.MC_CNT_W(6)) dut (
    .clk(clk), .rst_(rst_), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
    .mc_start(mc_start), .mc_len(mc_len), .flush_req(flush_req), .flush_pc(flush_pc),
    .stall(stall), .flush(flush), .new_pc(new_pc), .mc_busy(mc_busy), .mc_done(mc_done)
`ifdef STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, id, ex, st;
    logic [5:0]  len;
    logic        fr;
    logic [31:0] fpc;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    logic        e_busy, e_done;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic id, input logic ex, input logic st,
                     input logic [5:0] len, input logic fr, input logic [31:0] fpc,
                     input logic [5:0] es, input logic ef, input logic [31:0] ep,
                     input logic eb, input logic ed);
    vec_t v;
    v.rst = r; v.id = id; v.ex = ex; v.st = st; v.len = len; v.fr = fr; v.fpc = fpc;
    v.e_stall = es; v.e_flush = ef; v.e_pc = ep; v.e_busy = eb; v.e_done = ed;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic drive(input logic r, input logic id, input logic ex, input logic st,
                       input logic [5:0] len, input logic fr, input logic [31:0] fpc);
    rst_ = r; stallreq_id = id; stallreq_ex = ex; mc_start = st; mc_len = len;
    flush_req = fr; flush_pc = fpc;
  endtask

  // Reference model state: remaining MC_RUN cycles, pending done, flush register, redirect PC.
  int          m_rem;
  logic        m_done, m_flush;
  logic [31:0] m_pc;

  function automatic logic [5:0] model_stall();
    logic mc_stall;
    mc_stall = (m_rem > 0) || (mc_start && !flush_req);
    if (rst_ || m_flush) return 6'b000000;
    if (stallreq_ex || mc_stall) return 6'b001111;
    if (stallreq_id) return 6'b000111;
    return 6'b000000;
  endfunction

  task automatic model_step();
    int l;
    if (rst_) begin
      m_rem = 0; m_done = 1'b0; m_flush = 1'b0; m_pc = 32'h0;
    end else if (flush_req) begin
      m_rem = 0; m_done = 1'b0; m_flush = 1'b1; m_pc = flush_pc;
    end else begin
      m_flush = 1'b0;
      if (m_rem > 0) begin
        m_rem = m_rem - 1;
        m_done = (m_rem == 0);
      end else if (mc_start) begin
        l = (mc_len == 6'd0) ? 1 : int'(mc_len);
        m_rem = l - 1;
        m_done = (l == 1);
      end else begin
        m_done = 1'b0;
      end
    end
  endtask

  initial begin
    int first_done;
    int hit;

    // rst id ex st len fr fpc | stall flush new_pc busy done
    add(1,1,1,1,6'd5,1,32'h1234, 6'h00,0,32'h0,0,0);
    add(1,1,1,1,6'd5,1,32'h1234, 6'h00,0,32'h0,0,0);
    add(1,1,1,1,6'd5,1,32'h1234, 6'h00,0,32'h0,0,0);
    add(0,0,0,0,6'd0,0,32'h0,    6'h00,0,32'h0,0,0);
    add(0,1,0,0,6'd0,0,32'h0,    6'h07,0,32'h0,0,0);
    add(0,1,1,0,6'd0,0,32'h0,    6'h0F,0,32'h0,0,0);
    add(0,1,1,0,6'd0,1,32'h100,  6'h0F,0,32'h0,0,0);
    add(0,1,1,0,6'd0,0,32'h0,    6'h00,1,32'h100,0,0);
    add(0,0,0,0,6'd0,0,32'h0,    6'h00,0,32'h100,0,0);
    add(0,0,0,1,6'd5,0,32'h0,    6'h0F,0,32'h100,0,0);
    for (int i = 0; i < 4; i++) add(0,0,0,0,6'd0,0,32'h0, 6'h0F,0,32'h100,1,0);
    add(0,0,0,0,6'd0,0,32'h0,    6'h00,0,32'h100,0,1);
    add(0,0,0,0,6'd0,0,32'h0,    6'h00,0,32'h100,0,0);
    add(0,0,0,1,6'd0,0,32'h0,    6'h0F,0,32'h100,0,0);
    add(0,0,0,0,6'd0,0,32'h0,    6'h00,0,32'h100,0,1);
    add(0,0,0,1,6'd1,0,32'h0,    6'h0F,0,32'h100,0,0);
    add(0,0,0,1,6'd2,0,32'h0,    6'h0F,0,32'h100,0,1);
    add(0,0,0,0,6'd0,0,32'h0,    6'h0F,0,32'h100,1,0);
    add(0,0,0,0,6'd0,0,32'h0,    6'h00,0,32'h100,0,1);
    add(0,0,0,0,6'd0,0,32'h0,    6'h00,0,32'h100,0,0);
    add(0,0,0,1,6'd20,0,32'h0,   6'h0F,0,32'h100,0,0);
    for (int i = 0; i < 3; i++) add(0,0,0,0,6'd0,0,32'h0, 6'h0F,0,32'h100,1,0);
    add(0,0,0,0,6'd0,1,32'h180,  6'h0F,0,32'h100,1,0);
    add(0,0,0,0,6'd0,0,32'h0,    6'h00,1,32'h180,0,0);
    add(0,0,0,0,6'd0,0,32'h0,    6'h00,0,32'h180,0,0);
    add(0,0,0,0,6'd0,0,32'h0,    6'h00,0,32'h180,0,0);
    add(0,0,0,0,6'd0,1,32'h200,  6'h00,0,32'h180,0,0);
    add(0,0,0,0,6'd0,1,32'h204,  6'h00,1,32'h200,0,0);
    add(0,0,0,0,6'd0,0,32'h0,    6'h00,1,32'h204,0,0);
    add(0,0,0,0,6'd0,0,32'h0,    6'h00,0,32'h204,0,0);
    add(0,0,0,1,6'd10,0,32'h0,   6'h0F,0,32'h204,0,0);
    add(0,0,0,0,6'd0,0,32'h0,    6'h0F,0,32'h204,1,0);
    add(1,0,0,0,6'd0,1,32'h999,  6'h00,0,32'h204,1,0);
    add(0,0,0,0,6'd0,0,32'h0,    6'h00,0,32'h0,0,0);

    drive(1,0,0,0,6'd0,0,32'h0);
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      drive(vecs[i].rst, vecs[i].id, vecs[i].ex, vecs[i].st, vecs[i].len, vecs[i].fr, vecs[i].fpc);
      @(negedge clk);
      chk($sformatf("vec%0d_stall", i), {26'h0, stall}, {26'h0, vecs[i].e_stall});
      chk($sformatf("vec%0d_flush", i), {31'h0, flush}, {31'h0, vecs[i].e_flush});
      chk($sformatf("vec%0d_new_pc", i), new_pc, vecs[i].e_pc);
      chk($sformatf("vec%0d_busy", i), {31'h0, mc_busy}, {31'h0, vecs[i].e_busy});
      chk($sformatf("vec%0d_done", i), {31'h0, mc_done}, {31'h0, vecs[i].e_done});
    end

    // mc_start held during MC_RUN must not extend a 3-cycle op.
    @(posedge clk); #1; drive(1,0,0,0,6'd0,0,32'h0);
    @(posedge clk); #1; drive(0,0,0,1,6'd3,0,32'h0);
    first_done = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1; drive(0,0,0,1,6'd9,0,32'h0);
      @(negedge clk);
      if (mc_done && first_done == 0) first_done = k;
    end
    chk("mc_start_ignored_in_run", first_done, 32'd3);

`ifdef STALL_CNT_EN
    @(posedge clk); #1; drive(1,0,0,0,6'd0,0,32'h0);
    @(posedge clk); #1; drive(0,1,0,0,6'd0,0,32'h0);
    repeat (7) @(posedge clk);
    #1; drive(0,0,0,0,6'd0,0,32'h0);
    @(negedge clk);
    chk("stall_cycles_7", stall_cycles, 32'd7);
    force dut.stall_cycles_r = 32'hFFFF_FFFE;
    #1; release dut.stall_cycles_r;
    drive(0,1,0,0,6'd0,0,32'h0);
    repeat (3) @(posedge clk);
    #1; drive(0,0,0,0,6'd0,0,32'h0);
    @(negedge clk);
    chk("stall_cycles_sat", stall_cycles, 32'hFFFF_FFFF);
`endif

    // Randomized run against the reference model.
    @(posedge clk); #1; drive(1,0,0,0,6'd0,0,32'h0);
    m_rem = 0; m_done = 1'b0; m_flush = 1'b0; m_pc = 32'h0;
    hit = 0;
    for (int c = 0; c < 3000; c++) begin
      logic r, fr, st;
      @(posedge clk); #1;
      r  = ($urandom_range(0, 63) == 0);
      fr = ($urandom_range(0, 15) == 0);
      st = !fr && ($urandom_range(0, 5) == 0);
      drive(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), st,
            6'($urandom_range(0, 12)), fr, $urandom);
      @(negedge clk);
      if (mc_done) hit++;
      chk("rand_stall", {26'h0, stall}, {26'h0, model_stall()});
      chk("rand_flush", {31'h0, flush}, {31'h0, m_flush});
      chk("rand_new_pc", new_pc, m_pc);
      chk("rand_busy", {31'h0, mc_busy}, {31'h0, (m_rem > 0)});
      chk("rand_done", {31'h0, mc_done}, {31'h0, m_done});
      model_step();
    end
    chk("rand_done_seen", {31'h0, (hit > 0)}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
